// File: rtl/dmem_unit_pkg.sv
// Shared types and constants for the data-memory unit: access sizes, timer
// register selects, default region bases and the load extension helper.
package dmem_unit_pkg;

  localparam int unsigned MEM_TYPE_W = 2;

  typedef enum logic [MEM_TYPE_W-1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_type_t;

  // Timer register word selects (byte offset >> 2)
  localparam logic [1:0] TMR_MTIME_LO = 2'd0;
  localparam logic [1:0] TMR_MTIME_HI = 2'd1;
  localparam logic [1:0] TMR_CMP_LO   = 2'd2;
  localparam logic [1:0] TMR_CMP_HI   = 2'd3;

  localparam logic [31:0] DEFAULT_RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TIMER_BASE = 32'h0200_0000;

  // Shift the addressed lane(s) down to bit 0 and extend to 32 bits
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input mem_type_t   t,
                                              input logic        sgn);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (t)
      MEM_B:   load_extend = {{24{sgn & sh[7]}}, sh[7:0]};
      MEM_H:   load_extend = {{16{sgn & sh[15]}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

endpackage

// File: rtl/dmem_unit_if.sv
// MEM-stage to data-memory bus: request fields from the core, load data,
// timer interrupt and misalignment pulse back.
interface dmem_unit_if;
  import dmem_unit_pkg::*;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  mem_type_t   mem_type;
  logic        mem_sign;
  logic        rmem;
  logic        wmem;
  logic [31:0] mem_rdata;
  logic        timer_irq;
  logic        misalign;

  modport master (
    output mem_addr, mem_wdata, mem_type, mem_sign, rmem, wmem,
    input  mem_rdata, timer_irq, misalign
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_type, mem_sign, rmem, wmem,
    output mem_rdata, timer_irq, misalign
  );

endinterface

// File: rtl/dmem_timer.sv
// Machine timer: prescaled 64-bit mtime, 64-bit mtimecmp, 32-bit register
// port and a registered mtime >= mtimecmp interrupt.
module dmem_timer
  import dmem_unit_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr_en,
  input  logic [1:0]  sel,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data_c,
  output logic        timer_irq
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc_q, presc_nxt;
  logic [63:0]   mtime_q, mtime_nxt;
  logic [63:0]   cmp_q, cmp_nxt;
  logic          tick;
  logic          irq_q;

  // Next-state: increment first, then a register store overrides its half
  always_comb begin
    tick      = (presc_q == PW'(TICK_DIV - 1));
    presc_nxt = tick ? '0 : presc_q + PW'(1);
    mtime_nxt = tick ? mtime_q + 64'd1 : mtime_q;
    cmp_nxt   = cmp_q;
    if (wr_en) begin
      case (sel)
        TMR_MTIME_LO: mtime_nxt[31:0]  = wr_data;
        TMR_MTIME_HI: mtime_nxt[63:32] = wr_data;
        TMR_CMP_LO:   cmp_nxt[31:0]    = wr_data;
        default:      cmp_nxt[63:32]   = wr_data;
      endcase
    end
  end

  always_comb begin
    case (sel)
      TMR_MTIME_LO: rd_data_c = mtime_q[31:0];
      TMR_MTIME_HI: rd_data_c = mtime_q[63:32];
      TMR_CMP_LO:   rd_data_c = cmp_q[31:0];
      default:      rd_data_c = cmp_q[63:32];
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q <= '0;
      mtime_q <= '0;
      cmp_q   <= '1;
      irq_q   <= 1'b0;
    end else begin
      presc_q <= presc_nxt;
      mtime_q <= mtime_nxt;
      cmp_q   <= cmp_nxt;
      irq_q   <= (mtime_q >= cmp_q);
    end
  end

  assign timer_irq = irq_q;

endmodule

// File: rtl/dmem_unit.sv
// Data memory unit: byte-lane word RAM plus memory-mapped machine timer,
// with registered, lane-extracted load data. Optional: DMEM_MISALIGN_CHK_EN.
module dmem_unit
  import dmem_unit_pkg::*;
#(
  parameter int unsigned DEPTH      = 4096,
  parameter logic [31:0] RAM_BASE   = DEFAULT_RAM_BASE,
  parameter logic [31:0] TIMER_BASE = DEFAULT_TIMER_BASE,
  parameter int unsigned TICK_DIV   = 1
) (
  input logic       clk,
  input logic       rstn,
  dmem_unit_if.slave bus
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  logic [31:0]   ram [DEPTH];
  logic [AW-1:0] idx;
  logic [31:0]   ram_off;
  logic          ram_hit, tmr_hit;
  logic          mis_block;
  logic [1:0]    lane_off;
  logic [3:0]    be;
  logic [31:0]   wlanes;
  logic          st_ok, ld_ok, ram_we, tmr_we;
  logic [31:0]   tmr_rd_c, rd_word, rdata_nxt;
  logic [31:0]   rdata_q;
  logic          misalign_q;

`ifdef DMEM_MISALIGN_CHK_EN
  assign mis_block = ((bus.mem_type == MEM_H) &&  bus.mem_addr[0]) ||
                     ((bus.mem_type == MEM_W) && (bus.mem_addr[1:0] != 2'b00));
`else
  assign mis_block = 1'b0;
`endif

  // Decode, lane steering and load/store qualification
  always_comb begin
    ram_off = bus.mem_addr - RAM_BASE;
    ram_hit = (ram_off < RAM_BYTES);
    tmr_hit = (bus.mem_addr[31:4] == TIMER_BASE[31:4]);
    idx     = bus.mem_addr[AW+1:2];
    case (bus.mem_type)
      MEM_B: begin
        lane_off = bus.mem_addr[1:0];
        be       = 4'b0001 << bus.mem_addr[1:0];
        wlanes   = {4{bus.mem_wdata[7:0]}};
      end
      MEM_H: begin
        lane_off = {bus.mem_addr[1], 1'b0};
        be       = bus.mem_addr[1] ? 4'b1100 : 4'b0011;
        wlanes   = {2{bus.mem_wdata[15:0]}};
      end
      MEM_W: begin
        lane_off = 2'b00;
        be       = 4'b1111;
        wlanes   = bus.mem_wdata;
      end
      default: begin
        lane_off = 2'b00;
        be       = 4'b0000;
        wlanes   = bus.mem_wdata;
      end
    endcase
    st_ok  = bus.wmem & ~mis_block;
    ld_ok  = bus.rmem & ~bus.wmem & ~mis_block;
    ram_we = st_ok & ram_hit;
    tmr_we = st_ok & tmr_hit & (bus.mem_type == MEM_W);
    if (ram_hit)      rd_word = ram[idx];
    else if (tmr_hit) rd_word = tmr_rd_c;
    else              rd_word = 32'h0;
    rdata_nxt = ld_ok ? load_extend(rd_word, lane_off, bus.mem_type, bus.mem_sign)
                      : 32'h0;
  end

  // RAM contents are deliberately left out of reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we && be[b]) ram[idx][8*b +: 8] <= wlanes[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q    <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      rdata_q    <= rdata_nxt;
      misalign_q <= (bus.rmem | bus.wmem) & mis_block;
    end
  end

  dmem_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en     (tmr_we),
    .sel       (bus.mem_addr[3:2]),
    .wr_data   (bus.mem_wdata),
    .rd_data_c (tmr_rd_c),
    .timer_irq (bus.timer_irq)
  );

  assign bus.mem_rdata = rdata_q;
  assign bus.misalign  = misalign_q;

endmodule

// File: doc/dmem_unit.md
Name: dmem_unit

Overview:
Data-side memory block directly downstream of the core's MEM stage. It consumes mem_addr, mem_wdata, mem_type, mem_sign, rmem and wmem, and returns mem_rdata one cycle later, aligned to the WB stage.
- Contains a byte-lane word RAM and a memory-mapped machine timer (mtime/mtimecmp) that drives timer_irq.
- Performs load lane extraction and sign/zero extension, so the core's WB stage consumes mem_rdata unchanged.

Parameters:
DEPTH, 4096, RAM size in 32-bit words; must be a power of 2; index width AW = log2(DEPTH).
RAM_BASE, 32'h0000_0000, RAM region base; region size is DEPTH*4 bytes.
TIMER_BASE, 32'h0200_0000, timer region base; region is 16 bytes.
TICK_DIV, 1, mtime increments once every TICK_DIV cycles; minimum 1.

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
mem_addr  in  32  byte address from MEM stage
mem_wdata  in  32  store data, right-aligned
mem_type  in  2  access size: MEM_B=2'b00, MEM_H=2'b01, MEM_W=2'b10
mem_sign  in  1  1 = sign-extend loads, 0 = zero-extend
rmem  in  1  load request
wmem  in  1  store request
mem_rdata  out  32  extended load data, valid the cycle after rmem
timer_irq  out  1  registered (mtime >= mtimecmp)
misalign  out  1  misaligned-access pulse; constant 0 unless DMEM_MISALIGN_CHK_EN is defined

Behaviour:
- Clock and reset: single clock clk; rstn is asynchronous and active-low.
- Reset values:
  - Outputs: mem_rdata=0, timer_irq=0, misalign=0.
  - Timer state: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0.
  - RAM contents are not reset.
  - Reset asserted mid-operation discards the pending read; the next cycle shows 0.
- Decode:
  - RAM hit when mem_addr is in [RAM_BASE, RAM_BASE+DEPTH*4); word index = mem_addr[AW+1:2].
  - Timer hit when mem_addr[31:4]==TIMER_BASE[31:4]. Offsets: 0x0 mtime[31:0], 0x4 mtime[63:32], 0x8 mtimecmp[31:0], 0xC mtimecmp[63:32].
  - Unmapped: loads return 0; stores are dropped.
- Store, wmem in cycle N: target updated at the rising edge ending cycle N.
  - B: mem_wdata[7:0] goes to lane mem_addr[1:0].
  - H: mem_wdata[15:0] goes to lanes {mem_addr[1],0}+1 : {mem_addr[1],0}.
  - W: all four lanes.
  - Timer registers accept W only; B/H stores to the timer are dropped.
- Load, rmem in cycle N: mem_rdata is valid during cycle N+1.
  - The selected lane(s) are shifted to bit 0 and extended per the mem_type/mem_sign values captured in cycle N.
  - Timer reads return the 32-bit register value and go through the same extraction.
- Read-after-write: a load in cycle N+1 to an address stored in cycle N returns the new data.
- rmem and wmem both high in the same cycle: the store is performed, the load is ignored, and mem_rdata=0 the next cycle.
- Cycle with no rmem: mem_rdata=0 the next cycle.
- Timer counting:
  - Prescaler counts 0..TICK_DIV-1; mtime+1 when the prescaler wraps. mtime wraps 2^64-1 to 0.
  - A store to an mtime half takes priority over that cycle's increment; the other half is unaffected.
- timer_irq: registered comparison, so it updates one cycle after mtime or mtimecmp changes. Software clears it by writing mtimecmp.
- Misalignment is H with addr[0]=1, or W with addr[1:0]!=0. Its handling depends on DMEM_MISALIGN_CHK_EN (see below).

Optional Feature:
DMEM_MISALIGN_CHK_EN
- Defined:
  - A misaligned store is suppressed: no state changes.
  - A misaligned load returns mem_rdata=0.
  - misalign pulses high for exactly one cycle, in cycle N+1 of the offending access (aligned with mem_rdata).
- Undefined:
  - The address is aligned down (H ignores bit 0, W ignores bits 1:0) and the access proceeds.
  - misalign is tied to 0.

Decomposition:
- Shared defines file holds: mem_type encodings MEM_B, MEM_H, MEM_W; `mem_type_bus; TIMER offsets; default TIMER_BASE and RAM_BASE.
- One sub-module, dmem_timer: prescaler, mtime, mtimecmp, register write/read port, registered timer_irq.
- The RAM array, decode, lane logic and read pipeline register stay in dmem_unit.

Test Plan:
1. SW 0x8765_4321 @0x10 (cycle N); LB sign=1 @0x13 (N+1) -> mem_rdata=0xFFFF_FF87 at N+2. LBU @0x13 -> 0x0000_0087.
2. SH 0xBEEF @0x22; LH sign=1 @0x22 -> 0xFFFF_BEEF; LW @0x20 -> 0xBEEF_xxxx, with lower lanes unchanged from the prior SW of 0x1111_1111 -> 0xBEEF_1111.
3. Simultaneous rmem=wmem=1, SW 0xA5A5_A5A5 @0x40 -> the word is written and mem_rdata=0 the next cycle. A following LW @0x40 -> 0xA5A5_A5A5.
4. TICK_DIV=1, write mtimecmp_hi=0 then mtimecmp_lo=20 -> timer_irq rises once mtime reaches 20, one cycle after the match. Writing mtimecmp_lo=0xFFFF_FFFF with hi=0xFFFF_FFFF drops the irq one cycle later.
5. LW @0x0300_0000 (unmapped) -> mem_rdata=0. SW @0x0300_0000 followed by a RAM readback -> no corruption.
6. With DMEM_MISALIGN_CHK_EN: SW 0x1234_5678 @0x41 -> misalign=1 for one cycle and the word @0x40 is unchanged. Without the macro, the same store writes 0x1234_5678 @0x40.
